// File: rtl/mips_cpu_store_unit.sv
// MIPS store unit: turns one sb/sh/sw/swl/swr request into a single
// Avalon-MM write with lane-shifted data and byteenable, holds the write
// across waitrequest, and reports completion (done) or failure (err).
// Lanes are little-endian: byte k occupies bits [8k+7:8k].
module mips_cpu_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  output logic        done,
  output logic        err
);

  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SWL = 6'b101010;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SWR = 6'b101110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        legal;
    logic [3:0]  be;
    logic [31:0] data;
  } lane_t;

  state_t      state;
  logic [31:0] tmo_cnt;
  lane_t       req_lane;
  logic        timeout_hit;

  // Byte-lane steering for every store flavour; anything not listed (or a
  // misaligned sh/sw) comes back with legal=0 and no lanes enabled.
  function automatic lane_t lane_encode(input logic [5:0]  op,
                                        input logic [1:0]  ofs,
                                        input logic [31:0] rt);
    lane_t r;
    r.legal = 1'b0;
    r.be    = 4'b0000;
    r.data  = 32'h0;
    case (op)
      OP_SB: begin
        r.legal = 1'b1;
        r.be    = 4'b0001 << ofs;
        r.data  = {4{rt[7:0]}};
      end
      OP_SH: begin
        if (!ofs[0]) begin
          r.legal = 1'b1;
          r.be    = ofs[1] ? 4'b1100 : 4'b0011;
          r.data  = {2{rt[15:0]}};
        end
      end
      OP_SW: begin
        if (ofs == 2'b00) begin
          r.legal = 1'b1;
          r.be    = 4'b1111;
          r.data  = rt;
        end
      end
      OP_SWL: begin
        r.legal = 1'b1;
        case (ofs)
          2'b00:   begin r.be = 4'b0001; r.data = {24'h0, rt[31:24]}; end
          2'b01:   begin r.be = 4'b0011; r.data = {16'h0, rt[31:16]}; end
          2'b10:   begin r.be = 4'b0111; r.data = {8'h0,  rt[31:8]};  end
          default: begin r.be = 4'b1111; r.data = rt;                 end
        endcase
      end
      OP_SWR: begin
        r.legal = 1'b1;
        case (ofs)
          2'b00:   begin r.be = 4'b1111; r.data = rt;                 end
          2'b01:   begin r.be = 4'b1110; r.data = {rt[23:0], 8'h0};  end
          2'b10:   begin r.be = 4'b1100; r.data = {rt[15:0], 16'h0}; end
          default: begin r.be = 4'b1000; r.data = {rt[7:0],  24'h0}; end
        endcase
      end
      default: begin
        r.legal = 1'b0;
      end
    endcase
    return r;
  endfunction

  assign req_lane  = lane_encode(req_opcode, req_addr[1:0], req_data);
  assign req_ready = (state == IDLE);

  // The stall that would bring the counter up to TIMEOUT_CYCLES ends the
  // transfer; a zero parameter disables the limit entirely.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((tmo_cnt + 32'd1) >= TIMEOUT_CYCLES);

  // Request capture, bus hold, and one-cycle done/err reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      avm_write      <= 1'b0;
      avm_address    <= 32'h0;
      avm_writedata  <= 32'h0;
      avm_byteenable <= 4'b0000;
      done           <= 1'b0;
      err            <= 1'b0;
      tmo_cnt        <= 32'h0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_lane.legal) begin
              avm_address    <= {req_addr[31:2], 2'b00};
              avm_writedata  <= req_lane.data;
              avm_byteenable <= req_lane.be;
              avm_write      <= 1'b1;
              tmo_cnt        <= 32'h0;
              state          <= BUS;
            end else begin
              err <= 1'b1;
            end
          end
        end
        BUS: begin
          // An accepted write takes priority over an expiring timeout.
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            done      <= 1'b1;
            state     <= RESP;
          end else if (timeout_hit) begin
            avm_write <= 1'b0;
            err       <= 1'b1;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          avm_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
